// File: rtl/pc_sequencer_if.sv
// Fetch/decode and run-control bundle between the PC sequencer and the rest of the core.
// The sequencer is the master: it owns the PC, the retire strobe and the status outputs.
interface pc_sequencer_if;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] i_imm;
   logic [31:0] b_imm;
   logic [31:0] j_imm;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        la_halt;
   logic        la_step;
   logic        la_run;
   logic        la_pc_load;
   logic [31:0] la_pc_value;
   logic        la_bp_en;
   logic [31:0] la_bp_pc;
   logic        la_clear_fault;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        retire;
   logic [1:0]  state;
   logic        fault;
   logic [31:0] cycle_count;
   logic [31:0] retire_count;

   modport master (
      input  opcode, funct3, i_imm, b_imm, j_imm, rs1_data, rs2_data,
      input  la_halt, la_step, la_run, la_pc_load, la_pc_value, la_bp_en, la_bp_pc,
      input  la_clear_fault,
      output pc, pc_plus4, retire, state, fault, cycle_count, retire_count
   );

   modport slave (
      output opcode, funct3, i_imm, b_imm, j_imm, rs1_data, rs2_data,
      output la_halt, la_step, la_run, la_pc_load, la_pc_value, la_bp_en, la_bp_pc,
      output la_clear_fault,
      input  pc, pc_plus4, retire, state, fault, cycle_count, retire_count
   );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter, branch resolution and logic-analyzer run control for a single-cycle core.
// retire gates every architectural write; it is combinational from pc and the decode inputs.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int unsigned IMEM_WORDS   = 16,
   parameter bit          START_HALTED = 1'b0
) (
   input logic            clk,
   input logic            rst_n,
   pc_sequencer_if.master bus
);

   typedef enum logic [1:0] {
      StRun   = 2'b00,
      StHalt  = 2'b01,
      StStep  = 2'b10,
      StFault = 2'b11
   } state_e;

   localparam logic [6:0]  OpBranch = 7'b1100011;
   localparam logic [6:0]  OpJal    = 7'b1101111;
   localparam logic [6:0]  OpJalr   = 7'b1100111;
   localparam logic [6:0]  OpSystem = 7'b1110011;
   localparam logic [31:0] PcMask   = (32'(IMEM_WORDS) * 32'd4 - 32'd1) & ~32'h3;
   localparam state_e      ResetSt  = START_HALTED ? StHalt : StRun;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        skip_q, skip_d;
   logic [31:0] cycle_q, retire_q;

   logic [31:0] pc_plus4;
   logic [31:0] jalr_sum;
   logic [31:0] target;
   logic        taken;
   logic        redirect;
   logic        misaligned;
   logic        bp_hit;
   logic        ebreak_hit;
   logic        retire;

   assign pc_plus4 = pc_q + 32'd4;
   assign jalr_sum = bus.rs1_data + bus.i_imm;

   always_comb begin
      taken = 1'b0;
      case (bus.funct3)
         3'b000:  taken = (bus.rs1_data == bus.rs2_data);
         3'b001:  taken = (bus.rs1_data != bus.rs2_data);
         3'b100:  taken = ($signed(bus.rs1_data) < $signed(bus.rs2_data));
         3'b101:  taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
         3'b110:  taken = (bus.rs1_data < bus.rs2_data);
         3'b111:  taken = (bus.rs1_data >= bus.rs2_data);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      target   = pc_plus4;
      redirect = 1'b0;
      case (bus.opcode)
         OpBranch: begin
            if (taken) begin
               target   = pc_q + bus.b_imm;
               redirect = 1'b1;
            end
         end
         OpJal: begin
            target   = pc_q + bus.j_imm;
            redirect = 1'b1;
         end
         OpJalr: begin
            target   = jalr_sum & ~32'h1;
            redirect = 1'b1;
         end
         default: ;
      endcase
   end

   assign misaligned = redirect && target[1];
   // The skip flag lets the instruction we stopped on execute once after resuming.
   assign bp_hit     = bus.la_bp_en && (pc_q == bus.la_bp_pc) && !skip_q;
   assign ebreak_hit = (bus.opcode == OpSystem) && (bus.i_imm == 32'd1) && !skip_q;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      skip_d  = skip_q;
      retire  = 1'b0;
      unique case (state_q)
         StRun: begin
            if (misaligned) begin
               state_d = StFault;
            end else if (bus.la_halt || bp_hit || ebreak_hit) begin
               state_d = StHalt;
            end else begin
               retire = 1'b1;
               pc_d   = target & PcMask;
            end
         end
         StHalt: begin
            if (bus.la_pc_load) begin
               pc_d = bus.la_pc_value & PcMask;
            end else if (bus.la_step) begin
               state_d = StStep;
               skip_d  = 1'b1;
            end else if (bus.la_run) begin
               state_d = StRun;
               skip_d  = 1'b1;
            end
         end
         StStep: begin
            if (misaligned) begin
               state_d = StFault;
            end else begin
               retire  = 1'b1;
               pc_d    = target & PcMask;
               state_d = StHalt;
            end
         end
         StFault: begin
            if (bus.la_clear_fault) begin
               pc_d    = RESET_PC;
               skip_d  = 1'b0;
               state_d = StHalt;
            end
         end
         default: state_d = StFault;
      endcase
      if (retire) skip_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ResetSt;
         pc_q     <= RESET_PC;
         skip_q   <= 1'b0;
         cycle_q  <= 32'd0;
         retire_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         skip_q  <= skip_d;
         cycle_q <= cycle_q + 32'd1;
         if (retire) retire_q <= retire_q + 32'd1;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pc_plus4     = pc_plus4;
   assign bus.retire       = retire;
   assign bus.state        = state_q;
   assign bus.fault        = (state_q == StFault);
   assign bus.cycle_count  = cycle_q;
   assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed walk through the run-control scenarios followed by randomized traffic,
// every cycle checked against an arithmetic reference model of the sequencer.
module tb_pc_sequencer;
   localparam int unsigned WORDS = 16;
   localparam int M_RUN   = 0;
   localparam int M_HALT  = 1;
   localparam int M_STEP  = 2;
   localparam int M_FAULT = 3;
   localparam logic [6:0] NOP  = 7'b0010011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JAL  = 7'b1101111;
   localparam logic [6:0] JALR = 7'b1100111;
   localparam logic [6:0] SYS  = 7'b1110011;
   localparam logic [6:0] ALU  = 7'b0110011;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;

   logic [31:0] m_pc;
   int          m_state;
   bit          m_skip;
   logic [31:0] m_cyc;
   logic [31:0] m_ret;
   logic [31:0] saved;

   pc_sequencer_if sif ();

   pc_sequencer #(
      .RESET_PC     (32'h0),
      .IMEM_WORDS   (WORDS),
      .START_HALTED (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (sif)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] wrap(input logic [31:0] x);
      int unsigned span = WORDS * 4;
      return (x % span) / 4 * 4;
   endfunction

   function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] b);
      case (f3)
         3'd0:    return a == b;
         3'd1:    return a != b;
         3'd4:    return $signed(a) < $signed(b);
         3'd5:    return $signed(a) >= $signed(b);
         3'd6:    return a < b;
         3'd7:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_eval(output bit ret, output logic [31:0] npc, output int nst,
                             output bit nskip);
      logic [31:0] tgt;
      bit redir, mis, eb, bp;
      tgt   = m_pc + 32'd4;
      redir = 1'b0;
      if (sif.opcode == BR && br_taken(sif.funct3, sif.rs1_data, sif.rs2_data)) begin
         tgt = m_pc + sif.b_imm;
         redir = 1'b1;
      end else if (sif.opcode == JAL) begin
         tgt = m_pc + sif.j_imm;
         redir = 1'b1;
      end else if (sif.opcode == JALR) begin
         tgt = sif.rs1_data + sif.i_imm;
         tgt[0] = 1'b0;
         redir = 1'b1;
      end
      mis = redir && tgt[1];
      eb  = (sif.opcode == SYS) && (sif.i_imm == 32'd1) && !m_skip;
      bp  = sif.la_bp_en && (sif.la_bp_pc == m_pc) && !m_skip;
      ret = 1'b0;
      npc = m_pc;
      nst = m_state;
      nskip = m_skip;
      if (m_state == M_RUN) begin
         if (mis) nst = M_FAULT;
         else if (sif.la_halt || bp || eb) nst = M_HALT;
         else begin ret = 1'b1; npc = wrap(tgt); end
      end else if (m_state == M_HALT) begin
         if (sif.la_pc_load) npc = wrap(sif.la_pc_value);
         else if (sif.la_step) begin nst = M_STEP; nskip = 1'b1; end
         else if (sif.la_run) begin nst = M_RUN; nskip = 1'b1; end
      end else if (m_state == M_STEP) begin
         if (mis) nst = M_FAULT;
         else begin ret = 1'b1; npc = wrap(tgt); nst = M_HALT; end
      end else if (sif.la_clear_fault) begin
         npc = 32'h0; nskip = 1'b0; nst = M_HALT;
      end
      if (ret) nskip = 1'b0;
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_state = M_RUN; m_skip = 1'b0; m_cyc = 32'h0; m_ret = 32'h0;
   endtask

   // Check the visible outputs for the current inputs, then advance one clock.
   task automatic tick(input string tag);
      bit ret, nskip;
      logic [31:0] npc;
      int nst;
      #1;
      model_eval(ret, npc, nst, nskip);
      chk({tag, ".pc"}, sif.pc, m_pc);
      chk({tag, ".state"}, 32'(sif.state), 32'(m_state));
      chk({tag, ".fault"}, 32'(sif.fault), 32'(m_state == M_FAULT));
      chk({tag, ".retire"}, 32'(sif.retire), 32'(ret));
      chk({tag, ".pc_plus4"}, sif.pc_plus4, m_pc + 32'd4);
      chk({tag, ".cycles"}, sif.cycle_count, m_cyc);
      chk({tag, ".retires"}, sif.retire_count, m_ret);
      @(posedge clk);
      m_pc = npc; m_state = nst; m_skip = nskip; m_cyc = m_cyc + 32'd1;
      if (ret) m_ret = m_ret + 32'd1;
      #1;
   endtask

   task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] ii,
                         input logic [31:0] bi, input logic [31:0] ji, input logic [31:0] r1,
                         input logic [31:0] r2);
      sif.opcode = op; sif.funct3 = f3; sif.i_imm = ii; sif.b_imm = bi; sif.j_imm = ji;
      sif.rs1_data = r1; sif.rs2_data = r2;
   endtask

   task automatic la_idle();
      sif.la_halt = 1'b0; sif.la_step = 1'b0; sif.la_run = 1'b0; sif.la_pc_load = 1'b0;
      sif.la_pc_value = 32'h0; sif.la_clear_fault = 1'b0;
   endtask

   initial begin
      int v;
      la_idle();
      sif.la_bp_en = 1'b0;
      sif.la_bp_pc = 32'h0;
      set_op(NOP, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      model_reset();
      #12;
      chk("reset.pc", sif.pc, 32'h0);
      chk("reset.state", 32'(sif.state), 32'd0);
      chk("reset.fault", 32'(sif.fault), 32'd0);
      chk("reset.cycles", sif.cycle_count, 32'd0);
      chk("reset.retires", sif.retire_count, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) tick("nop");
      chk("nop.pc16", sif.pc, 32'd16);
      chk("nop.retires4", sif.retire_count, 32'd4);
      chk("nop.cycles4", sif.cycle_count, 32'd4);

      // Back to pc=12 for the branch cases.
      set_op(JAL, 3'd0, 32'h0, 32'h0, -32'sd4, 32'h0, 32'h0);
      tick("jal_back");
      set_op(BR, 3'd0, 32'h0, 32'd16, 32'h0, 32'd5, 32'd5);
      tick("beq_taken");
      chk("beq_taken.pc", sif.pc, 32'd28);
      set_op(JAL, 3'd0, 32'h0, 32'h0, -32'sd16, 32'h0, 32'h0);
      tick("jal_to12");
      set_op(BR, 3'd0, 32'h0, 32'd16, 32'h0, 32'd5, 32'd6);
      tick("beq_not");
      chk("beq_not.pc", sif.pc, 32'd16);
      set_op(BR, 3'd6, 32'h0, 32'd8, 32'h0, 32'hFFFF_FFFF, 32'd1);
      tick("bltu");
      chk("bltu.pc", sif.pc, 32'd20);
      set_op(BR, 3'd4, 32'h0, 32'd8, 32'h0, 32'hFFFF_FFFF, 32'd1);
      tick("blt");
      chk("blt.pc", sif.pc, 32'd28);
      set_op(JAL, 3'd0, 32'h0, 32'h0, 32'd32, 32'h0, 32'h0);
      tick("jal_to60");
      set_op(JAL, 3'd0, 32'h0, 32'h0, -32'sd60, 32'h0, 32'h0);
      #1;
      chk("jal.link", sif.pc_plus4, 32'd64);
      tick("jal_m60");
      chk("jal_m60.pc", sif.pc, 32'd0);
      set_op(JALR, 3'd0, -32'sd3, 32'h0, 32'h0, 32'd8, 32'h0);
      tick("jalr");
      chk("jalr.pc", sif.pc, 32'd4);
      set_op(JALR, 3'd0, 32'h0, 32'h0, 32'h0, 32'd6, 32'h0);
      tick("jalr_mis");
      chk("jalr_mis.fault", 32'(sif.fault), 32'd1);
      chk("jalr_mis.pc", sif.pc, 32'd4);
      set_op(NOP, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      tick("fault_hold");
      sif.la_clear_fault = 1'b1;
      tick("clear");
      la_idle();
      chk("clear.state", 32'(sif.state), 32'(M_HALT));
      chk("clear.pc", sif.pc, 32'd0);

      sif.la_bp_en = 1'b1;
      sif.la_bp_pc = 32'd8;
      sif.la_run = 1'b1;
      tick("bp_run");
      la_idle();
      for (int i = 0; i < 3; i++) tick("bp_walk");
      chk("bp.state", 32'(sif.state), 32'(M_HALT));
      chk("bp.pc", sif.pc, 32'd8);
      saved = sif.retire_count;
      sif.la_step = 1'b1;
      tick("step_req");
      la_idle();
      tick("step_exec");
      chk("step.pc", sif.pc, 32'd12);
      chk("step.state", 32'(sif.state), 32'(M_HALT));
      chk("step.one_retire", sif.retire_count, saved + 32'd1);
      sif.la_pc_load = 1'b1;
      sif.la_pc_value = 32'd8;
      tick("load8");
      la_idle();
      sif.la_run = 1'b1;
      tick("resume");
      la_idle();
      tick("resume_at_bp");
      chk("resume.pc", sif.pc, 32'd12);
      saved = sif.retire_count;
      sif.la_halt = 1'b1;
      tick("halt_req");
      la_idle();
      chk("halt.state", 32'(sif.state), 32'(M_HALT));
      chk("halt.retires", sif.retire_count, saved);
      sif.la_bp_en = 1'b0;
      sif.la_pc_load = 1'b1;
      sif.la_pc_value = 32'h47;
      tick("load47");
      chk("load47.pc", sif.pc, 32'd4);
      sif.la_pc_value = 32'h10;
      sif.la_step = 1'b1;
      tick("load_step");
      la_idle();
      chk("load_step.pc", sif.pc, 32'd16);
      chk("load_step.state", 32'(sif.state), 32'(M_HALT));

      sif.la_run = 1'b1;
      tick("eb_run");
      la_idle();
      tick("eb_nop16");
      set_op(SYS, 3'd0, 32'd1, 32'h0, 32'h0, 32'h0, 32'h0);
      tick("ebreak");
      chk("ebreak.state", 32'(sif.state), 32'(M_HALT));
      chk("ebreak.pc", sif.pc, 32'd20);
      sif.la_run = 1'b1;
      tick("eb_resume");
      la_idle();
      tick("eb_as_nop");
      chk("eb_as_nop.pc", sif.pc, 32'd24);

      for (int n = 0; n < 600; n++) begin
         int pick = int'($urandom_range(0, 9));
         logic [31:0] vals [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000};
         v = (int'($urandom_range(0, 32)) - 16) * 4 + (($urandom_range(0, 3) == 0) ? 2 : 0);
         sif.funct3   = 3'($urandom_range(0, 7));
         sif.b_imm    = 32'(v);
         sif.j_imm    = 32'(v);
         sif.i_imm    = 32'(int'($urandom_range(0, 16)) - 8);
         sif.rs1_data = vals[$urandom_range(0, 4)];
         sif.rs2_data = vals[$urandom_range(0, 4)];
         case (pick)
            4, 5:    sif.opcode = BR;
            6:       sif.opcode = JAL;
            7:       begin sif.opcode = JALR; sif.rs1_data = 32'($urandom_range(0, 63)); end
            8:       begin sif.opcode = SYS; sif.i_imm = 32'd1; end
            9:       sif.opcode = ALU;
            default: sif.opcode = NOP;
         endcase
         sif.la_halt        = ($urandom_range(0, 15) == 0);
         sif.la_step        = ($urandom_range(0, 3) == 0);
         sif.la_run         = ($urandom_range(0, 3) == 0);
         sif.la_pc_load     = ($urandom_range(0, 7) == 0);
         sif.la_pc_value    = $urandom;
         sif.la_bp_en       = ($urandom_range(0, 3) == 0);
         sif.la_bp_pc       = 32'($urandom_range(0, 15) * 4);
         sif.la_clear_fault = ($urandom_range(0, 2) == 0);
         tick("rand");
      end

      la_idle();
      sif.la_bp_en = 1'b0;
      set_op(NOP, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("midreset.pc", sif.pc, 32'h0);
      chk("midreset.state", 32'(sif.state), 32'd0);
      chk("midreset.cycles", sif.cycle_count, 32'd0);
      chk("midreset.retires", sif.retire_count, 32'd0);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick("post_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
